// File: rtl/cpu_hazard_ctrl.sv
// cpu_hazard_ctrl
// Decode-stage data-hazard controller for the MCS8 pipeline. Compares each
// decode source operand against the M and W stage destinations to pick a
// forwarding path. A per-register countdown scoreboard tracks loads still in
// flight and drives the stall/bubble request. A saturating counter records
// how many cycles the pipeline spent stalled.

module cpu_hazard_ctrl #(
    parameter int REG_AW   = 3,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     D_VALID_I,
    input  logic [NSRC*REG_AW-1:0]   D_SRC_I,
    input  logic [NSRC-1:0]          D_SRC_CS_I,
    input  logic                     FLUSH_I,
    input  logic                     M_VALID_I,
    input  logic [REG_AW-1:0]        M_DSTR_I,
    input  logic                     M_DSTR_CS_I,
    input  logic                     M_LOAD_I,
    input  logic                     W_VALID_I,
    input  logic [REG_AW-1:0]        W_DSTR_I,
    input  logic                     W_DSTR_CS_I,
    input  logic                     W_LOAD_I,
    output logic [2*NSRC-1:0]        FWD_SEL_O,
    output logic                     STALL_O,
    output logic [(2**REG_AW)-1:0]   BUSY_O,
    output logic [CNT_W-1:0]         STALL_CNT_O
);

    localparam int NREG = 2**REG_AW;
    localparam int CW   = $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(LOAD_LAT);

    logic [CW-1:0]    cnt_q [NREG];
    logic [CW-1:0]    cnt_d [NREG];
    logic [CNT_W-1:0] stallCnt_q;
    logic [CNT_W-1:0] stallCnt_d;
    logic [NSRC-1:0]  hazard;
    logic             mLoadIssue;

    assign mLoadIssue = M_VALID_I & M_DSTR_CS_I & M_LOAD_I;

    // Scoreboard next state: a load issuing in M re-arms its destination, every other busy entry counts down.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (mLoadIssue && (M_DSTR_I == REG_AW'(r))) begin
                cnt_d[r] = LAT;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
    end

    // Scoreboard registers; reset drops all pending loads immediately.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Busy flags come straight from the countdown registers.
    for (genvar r = 0; r < NREG; r++) begin : g_busy
        assign BUSY_O[r] = (cnt_q[r] != '0);
    end

    // Per-source match, hazard and forwarding decision.
    for (genvar k = 0; k < NSRC; k++) begin : g_src
        logic [REG_AW-1:0] src;
        logic              rd;
        logic              srcBusy;
        logic              mMatch;
        logic              wMatch;

        assign src     = D_SRC_I[k*REG_AW +: REG_AW];
        assign rd      = D_VALID_I & D_SRC_CS_I[k];
        assign srcBusy = (cnt_q[src] != '0);
        assign mMatch  = rd & M_VALID_I & M_DSTR_CS_I & (src == M_DSTR_I);
        assign wMatch  = rd & W_VALID_I & W_DSTR_CS_I & (src == W_DSTR_I);

        assign hazard[k] = (mMatch & M_LOAD_I) | (rd & srcBusy);

        // A W-stage load result already sits in the regfile, so only non-load W results are forwarded.
        assign FWD_SEL_O[2*k +: 2] = (mMatch & ~M_LOAD_I)               ? 2'b01 :
                                     (wMatch & ~W_LOAD_I & ~srcBusy)    ? 2'b10 :
                                                                          2'b00;
    end

    assign STALL_O = (|hazard) & ~FLUSH_I;

    // Stall statistics next state: count stalled cycles, holding at all-ones.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (STALL_O && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // Stall statistics register.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign STALL_CNT_O = stallCnt_q;

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// tb_cpu_hazard_ctrl
// Self-checking bench for cpu_hazard_ctrl. The reference model remembers the
// cycle of the most recent load issued to each register and derives busy
// windows from elapsed time, then applies the hazard/forwarding rules.
// The statistics counter is narrowed so saturation is reachable quickly.

module tb_cpu_hazard_ctrl;

    localparam int REG_AW   = 3;
    localparam int NSRC     = 2;
    localparam int LOAD_LAT = 2;
    localparam int CNT_W    = 6;
    localparam int NREG     = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic       dValid;
        logic [2:0] src0;
        logic [2:0] src1;
        logic [1:0] srcCs;
        logic       flush;
        logic       mValid;
        logic [2:0] mDst;
        logic       mCs;
        logic       mLoad;
        logic       wValid;
        logic [2:0] wDst;
        logic       wCs;
        logic       wLoad;
    } stim_t;

    logic             clk;
    logic             rst;
    logic             dValid;
    logic [5:0]       dSrc;
    logic [1:0]       dSrcCs;
    logic             flush;
    logic             mValid;
    logic [2:0]       mDst;
    logic             mCs;
    logic             mLoad;
    logic             wValid;
    logic [2:0]       wDst;
    logic             wCs;
    logic             wLoad;
    logic [3:0]       fwdSel;
    logic             stall;
    logic [7:0]       busy;
    logic [CNT_W-1:0] stallCnt;

    int checkCount;
    int errCount;
    int cyc;
    int lastLoad [NREG];
    int expStallCnt;

    cpu_hazard_ctrl #(
        .REG_AW  (REG_AW),
        .NSRC    (NSRC),
        .LOAD_LAT(LOAD_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK_I      (clk),
        .RST_I      (rst),
        .D_VALID_I  (dValid),
        .D_SRC_I    (dSrc),
        .D_SRC_CS_I (dSrcCs),
        .FLUSH_I    (flush),
        .M_VALID_I  (mValid),
        .M_DSTR_I   (mDst),
        .M_DSTR_CS_I(mCs),
        .M_LOAD_I   (mLoad),
        .W_VALID_I  (wValid),
        .W_DSTR_I   (wDst),
        .W_DSTR_CS_I(wCs),
        .W_LOAD_I   (wLoad),
        .FWD_SEL_O  (fwdSel),
        .STALL_O    (stall),
        .BUSY_O     (busy),
        .STALL_CNT_O(stallCnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    // A register is busy during the LOAD_LAT cycles following its latest load issue.
    function automatic logic busyAt(input int r);
        int age;
        age = cyc - lastLoad[r];
        return (age >= 1) && (age <= LOAD_LAT);
    endfunction

    function automatic void modelReset();
        for (int r = 0; r < NREG; r++) lastLoad[r] = -1000;
        expStallCnt = 0;
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s.dValid = 0; s.src0 = 0; s.src1 = 0; s.srcCs = 0; s.flush = 0;
        s.mValid = 0; s.mDst = 0; s.mCs = 0; s.mLoad = 0;
        s.wValid = 0; s.wDst = 0; s.wCs = 0; s.wLoad = 0;
        return s;
    endfunction

    // Drive one decode cycle, check all outputs against the model, then advance across the clock edge.
    task automatic applyStimulus(input stim_t s);
        logic [3:0] expFwd;
        logic [7:0] expBusy;
        logic       hz;
        logic       expStall;
        logic [2:0] src;
        logic       rd;
        logic       mHit;
        logic       wHit;
        logic       sb;

        dValid = s.dValid;
        dSrc   = {s.src1, s.src0};
        dSrcCs = s.srcCs;
        flush  = s.flush;
        mValid = s.mValid; mDst = s.mDst; mCs = s.mCs; mLoad = s.mLoad;
        wValid = s.wValid; wDst = s.wDst; wCs = s.wCs; wLoad = s.wLoad;
        #1;

        expFwd = '0;
        hz     = 1'b0;
        for (int r = 0; r < NREG; r++) expBusy[r] = busyAt(r);
        for (int k = 0; k < NSRC; k++) begin
            src  = (k == 0) ? s.src0 : s.src1;
            rd   = s.dValid && s.srcCs[k];
            sb   = busyAt(int'(src));
            mHit = rd && s.mValid && s.mCs && (src == s.mDst);
            wHit = rd && s.wValid && s.wCs && (src == s.wDst);
            if ((mHit && s.mLoad) || (rd && sb)) hz = 1'b1;
            if (mHit && !s.mLoad)              expFwd[2*k +: 2] = 2'b01;
            else if (wHit && !s.wLoad && !sb)  expFwd[2*k +: 2] = 2'b10;
        end
        expStall = hz && !s.flush;

        checkOutput("fwdSel",   32'(fwdSel),   32'(expFwd));
        checkOutput("stall",    32'(stall),    32'(expStall));
        checkOutput("busy",     32'(busy),     32'(expBusy));
        checkOutput("stallCnt", 32'(stallCnt), 32'(expStallCnt));

        @(posedge clk);
        if (s.mValid && s.mCs && s.mLoad) lastLoad[s.mDst] = cyc;
        if (expStall && expStallCnt < CNT_MAX) expStallCnt++;
        cyc++;
        @(negedge clk);
    endtask

    // Pulse reset inside the low phase of the clock; state must clear without waiting for an edge.
    task automatic resetPulse();
        rst = 1'b1;
        #1;
        checkOutput("rstBusy",     32'(busy),     32'd0);
        checkOutput("rstStallCnt", 32'(stallCnt), 32'd0);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        stim_t s;
        checkCount = 0;
        errCount   = 0;
        cyc        = 0;
        modelReset();

        rst = 1'b1;
        dValid = 0; dSrc = 0; dSrcCs = 0; flush = 0;
        mValid = 0; mDst = 0; mCs = 0; mLoad = 0;
        wValid = 0; wDst = 0; wCs = 0; wLoad = 0;
        #1;
        $display("[TB] checking reset state");
        checkOutput("initBusy",     32'(busy),     32'd0);
        checkOutput("initStallCnt", 32'(stallCnt), 32'd0);
        checkOutput("initStall",    32'(stall),    32'd0);
        checkOutput("initFwd",      32'(fwdSel),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-load in M forwards to src0.
        $display("[TB] M forwarding");
        s = idleStim();
        s.dValid = 1; s.src0 = 3'd5; s.srcCs = 2'b01;
        s.mValid = 1; s.mDst = 3'd5; s.mCs = 1;
        applyStimulus(s);

        // Load-use on src1: three stall cycles, then clean.
        $display("[TB] load-use stall");
        s = idleStim();
        s.dValid = 1; s.src1 = 3'd2; s.srcCs = 2'b10;
        s.mValid = 1; s.mDst = 3'd2; s.mCs = 1; s.mLoad = 1;
        applyStimulus(s);
        s.mValid = 0; s.mLoad = 0;
        repeat (3) applyStimulus(s);

        // M and W both write r4: M wins; unread source forces regfile.
        $display("[TB] M/W priority");
        s = idleStim();
        s.dValid = 1; s.src0 = 3'd4; s.srcCs = 2'b01;
        s.mValid = 1; s.mDst = 3'd4; s.mCs = 1;
        s.wValid = 1; s.wDst = 3'd4; s.wCs = 1;
        applyStimulus(s);
        s.srcCs = 2'b00;
        applyStimulus(s);
        s.srcCs = 2'b01; s.mValid = 0;
        applyStimulus(s);
        s.wLoad = 1;
        applyStimulus(s);

        // Back-to-back loads to r1 re-arm the countdown.
        $display("[TB] load re-arm");
        s = idleStim();
        s.dValid = 1; s.src0 = 3'd1; s.srcCs = 2'b01;
        s.mValid = 1; s.mDst = 3'd1; s.mCs = 1; s.mLoad = 1;
        applyStimulus(s);
        applyStimulus(s);
        s.mValid = 0; s.mLoad = 0;
        repeat (4) applyStimulus(s);

        // Reset mid-countdown clears the scoreboard immediately.
        $display("[TB] reset mid-countdown");
        s = idleStim();
        s.mValid = 1; s.mDst = 3'd3; s.mCs = 1; s.mLoad = 1;
        applyStimulus(s);
        resetPulse();
        s = idleStim();
        s.dValid = 1; s.src0 = 3'd3; s.srcCs = 2'b01;
        applyStimulus(s);

        // Flush masks the stall and the count; then saturate the counter.
        $display("[TB] flush and saturation");
        s = idleStim();
        s.dValid = 1; s.src0 = 3'd2; s.srcCs = 2'b01; s.flush = 1;
        s.mValid = 1; s.mDst = 3'd2; s.mCs = 1; s.mLoad = 1;
        applyStimulus(s);
        applyStimulus(s);
        s.flush = 0; s.mDst = 3'd6; s.src0 = 3'd6;
        repeat (CNT_MAX + 5) applyStimulus(s);
        checkOutput("satHold", 32'(stallCnt), 32'(CNT_MAX));

        // Randomised traffic against the reference model.
        $display("[TB] random traffic");
        resetPulse();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(59, 0) == 0) resetPulse();
            s.dValid = ($urandom_range(7, 0) != 0);
            s.src0   = 3'($urandom_range(7, 0));
            s.src1   = 3'($urandom_range(7, 0));
            s.srcCs  = 2'($urandom_range(3, 0));
            s.flush  = ($urandom_range(7, 0) == 0);
            s.mValid = ($urandom_range(3, 0) != 0);
            s.mDst   = 3'($urandom_range(7, 0));
            s.mCs    = ($urandom_range(3, 0) != 0);
            s.mLoad  = ($urandom_range(2, 0) == 0);
            s.wValid = ($urandom_range(3, 0) != 0);
            s.wDst   = 3'($urandom_range(7, 0));
            s.wCs    = ($urandom_range(3, 0) != 0);
            s.wLoad  = ($urandom_range(2, 0) == 0);
            applyStimulus(s);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
